// File: rtl/fifo_1wmr_pkg.sv
// Shared scalar typedefs and helpers for the single-write, multi-read FIFO slice.
package fifo_1wmr_pkg;

  typedef logic        u1;
  typedef logic [31:0] u32;
  typedef logic [63:0] u64;

  // True when the set bits form a contiguous run starting at bit 0 (or none).
  function automatic u1 is_prefix_mask(input u32 m);
    return (m & (m + 32'd1)) == '0;
  endfunction

endpackage

// File: rtl/fifo_1wmr_rotate.sv
// Barrel rotator: lane i of the output takes input lane (i + shift) mod RNUM.
module fifo_1wmr_rotate
  import fifo_1wmr_pkg::*;
#(
  parameter type         TYPE = u64,
  parameter int unsigned RNUM = 4
) (
  input  logic [$clog2(RNUM)-1:0] shift_i,
  input  TYPE                     lanes_i [RNUM],
  output TYPE                     lanes_o [RNUM]
);

  localparam int unsigned BW = $clog2(RNUM);

  logic [BW-1:0] idx;

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < RNUM; i++) begin
      idx        = BW'(i) + shift_i;
      lanes_o[i] = lanes_i[idx];
    end
  end

endmodule

// File: rtl/fifo_1wmr.sv
// Single-write, multi-read circular FIFO: one push per cycle, up to RNUM in-order pops
// per cycle from RNUM-way banked storage.
module fifo_1wmr
  import fifo_1wmr_pkg::*;
#(
  parameter int unsigned QLEN = 16,
  parameter type         TYPE = u64,
  parameter int unsigned RNUM = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            write_valid,
  input  TYPE             write,
  output logic            write_ready,
  output logic [RNUM-1:0] read_valid,
  output TYPE             read [RNUM],
  input  logic [RNUM-1:0] read_en
);

  localparam int unsigned ROWS = QLEN / RNUM;
  localparam int unsigned BW   = $clog2(RNUM);
  localparam int unsigned OW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned PW   = $clog2(QLEN) + 1;

  localparam type ptr_t  = logic [PW-1:0];
  localparam type bank_t = logic [BW-1:0];
  localparam type off_t  = logic [OW-1:0];

  function automatic bank_t bank_of(input ptr_t p);
    return p[BW-1:0];
  endfunction

  function automatic off_t off_of(input ptr_t p);
    return (ROWS > 1) ? p[BW +: OW] : '0;
  endfunction

  ptr_t  head_q, head_d, tail_q, tail_d, count;
  u1     full, push;
  bank_t head_bank;
  off_t  head_off;
  off_t  rd_addr [RNUM];
  TYPE   bank_rd [RNUM];
  TYPE   mem_q   [RNUM][ROWS];

  assign count       = tail_q - head_q;
  assign full        = (head_q[PW-2:0] == tail_q[PW-2:0]) && (head_q[PW-1] != tail_q[PW-1]);
  assign write_ready = !full;
  assign push        = write_valid && write_ready;
  assign head_bank   = bank_of(head_q);
  assign head_off    = off_of(head_q);

  always_comb begin
    read_valid = '0;
    for (int unsigned i = 0; i < RNUM; i++) begin
      read_valid[i] = count > PW'(i);
    end
  end

  always_comb begin
    head_d = head_q + PW'($countones(read_en));
    tail_d = tail_q + PW'(push);
    if (reset || flush) begin
      head_d = '0;
      tail_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  always_ff @(posedge clk) begin
    if (push && !reset && !flush) begin
      mem_q[bank_of(tail_q)][off_of(tail_q)] <= write;
    end
  end

  // Banks below the head bank hold the entries that wrapped into the next row.
  always_comb begin
    for (int unsigned b = 0; b < RNUM; b++) begin
      rd_addr[b] = (ROWS > 1) ? head_off + off_t'(BW'(b) < head_bank) : '0;
      bank_rd[b] = mem_q[b][rd_addr[b]];
    end
  end

  fifo_1wmr_rotate #(
    .TYPE (TYPE),
    .RNUM (RNUM)
  ) u_rotate (
    .shift_i (head_bank),
    .lanes_i (bank_rd),
    .lanes_o (read)
  );

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      assert (is_prefix_mask(32'(read_en)))
        else $error("read_en is not a prefix mask: %b", read_en);
      assert ((read_en & ~read_valid) == '0)
        else $error("read_en pops beyond read_valid: en=%b valid=%b", read_en, read_valid);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_1wmr.sv
// Directed bench for fifo_1wmr at QLEN=8, RNUM=4, TYPE=u64.
module tb_fifo_1wmr;
  import fifo_1wmr_pkg::*;

  logic       clk = 1'b0;
  logic       reset, flush, write_valid, write_ready;
  u64         write_data;
  u64         rd [4];
  logic [3:0] read_valid, read_en;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fifo_1wmr #(
    .QLEN (8),
    .TYPE (u64),
    .RNUM (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .write_valid (write_valid),
    .write       (write_data),
    .write_ready (write_ready),
    .read_valid  (read_valid),
    .read        (rd),
    .read_en     (read_en)
  );

  task automatic check(input string tag, input u64 got, input u64 exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock; inputs then return to idle, sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    write_valid = 1'b0;
    read_en     = '0;
    flush       = 1'b0;
    reset       = 1'b0;
  endtask

  task automatic push(input u64 d);
    write_valid = 1'b1;
    write_data  = d;
    cyc();
  endtask

  task automatic pop(input logic [3:0] m);
    read_en = m;
    cyc();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cyc();
  endtask

  initial begin
    reset       = 1'b1;
    flush       = 1'b0;
    write_valid = 1'b0;
    write_data  = '0;
    read_en     = '0;
    cyc();
    check("rst_valid", 64'(read_valid), 64'h0);
    check("rst_ready", 64'(write_ready), 64'h1);

    // 1: three pushes, window shows them in order
    push(64'd1);
    check("t1_one_valid", 64'(read_valid), 64'b0001);
    push(64'd2);
    push(64'd3);
    check("t1_valid", 64'(read_valid), 64'b0111);
    check("t1_rd0", rd[0], 64'd1);
    check("t1_rd1", rd[1], 64'd2);
    check("t1_rd2", rd[2], 64'd3);

    // 2: fill to 8, extra push ignored
    do_flush();
    for (int i = 0; i < 8; i++) begin
      check("t2_ready_before", 64'(write_ready), 64'h1);
      push(64'(10 + i));
    end
    check("t2_full_ready", 64'(write_ready), 64'h0);
    check("t2_full_valid", 64'(read_valid), 64'b1111);
    push(64'd18);
    check("t2_still_full", 64'(write_ready), 64'h0);
    check("t2_rd0", rd[0], 64'd10);

    // 3: pop 4 from full; push in pop cycle rejected, accepted next cycle
    write_valid = 1'b1;
    write_data  = 64'h55;
    pop(4'b1111);
    check("t3_valid", 64'(read_valid), 64'b1111);
    check("t3_rd0", rd[0], 64'd14);
    check("t3_rd1", rd[1], 64'd15);
    check("t3_rd2", rd[2], 64'd16);
    check("t3_rd3", rd[3], 64'd17);
    check("t3_ready", 64'(write_ready), 64'h1);
    push(64'h99);
    pop(4'b1111);
    check("t3_after_valid", 64'(read_valid), 64'b0001);
    check("t3_after_rd0", rd[0], 64'h99);

    // 4: wrap, head at offset 5 (last row), window spans array end
    do_flush();
    for (int i = 0; i < 6; i++) push(64'(i));
    pop(4'b0011);
    check("t4_pop2_rd0", rd[0], 64'd2);
    pop(4'b0011);
    check("t4_pop4_rd0", rd[0], 64'd4);
    pop(4'b0001);
    for (int i = 6; i < 10; i++) push(64'(i));
    check("t4_valid", 64'(read_valid), 64'b1111);
    check("t4_rd0", rd[0], 64'd5);
    check("t4_rd1", rd[1], 64'd6);
    check("t4_rd2", rd[2], 64'd7);
    check("t4_rd3", rd[3], 64'd8);

    // 5: simultaneous push and pop-2 on three entries
    do_flush();
    push(64'h30);
    push(64'h31);
    push(64'h32);
    write_valid = 1'b1;
    write_data  = 64'hAA;
    pop(4'b0011);
    check("t5_valid", 64'(read_valid), 64'b0011);
    check("t5_rd0", rd[0], 64'h32);
    check("t5_rd1", rd[1], 64'hAA);

    // 6: flush outranks push and pop in the same cycle
    do_flush();
    for (int i = 0; i < 5; i++) push(64'(64'h40 + i));
    check("t6_pre_valid", 64'(read_valid), 64'b1111);
    flush       = 1'b1;
    write_valid = 1'b1;
    write_data  = 64'h77;
    pop(4'b0001);
    check("t6_valid", 64'(read_valid), 64'b0000);
    check("t6_ready", 64'(write_ready), 64'h1);
    push(64'h88);
    check("t6_after_valid", 64'(read_valid), 64'b0001);
    check("t6_after_rd0", rd[0], 64'h88);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
